irrigation_scheduler: RTL



---
 rtl/irrigation_pkg.sv | 29 ++
 rtl/input_debouncer.sv | 51 +++++
 rtl/irrigation_scheduler.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/irrigation_pkg.sv
// Shared types and helpers for the multi-zone irrigation scheduler.
package irrigation_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SELECT   = 3'd1,
    IRRIGATE = 3'd2,
    SOAK     = 3'd3,
    FAULT    = 3'd4
  } state_t;

  typedef enum logic {
    DRIPPER   = 1'b0,
    SPRINKLER = 1'b1
  } mode_t;

  localparam int MAX_LEVELS = 32;

  // A level vector is valid thermometer code when no set bit sits above a clear bit.
  function automatic logic is_thermometer(input logic [MAX_LEVELS-1:0] value, input int width);
    logic ok;
    ok = 1'b1;
    for (int i = 1; i < MAX_LEVELS; i++) begin
      if (i < width && value[i] && !value[i-1]) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/input_debouncer.sv
// Two-flop synchroniser followed by a per-bit debouncer: a bit is accepted
// only after the synchronised input has differed from it for CYCLES cycles.
module input_debouncer #(
  parameter int WIDTH  = 1,
  parameter int CYCLES = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] stable
);

  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic [CW-1:0] cnt;
    logic          stable_bit;

    // Any cycle where the input agrees with the accepted value restarts the count.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        cnt        <= '0;
        stable_bit <= 1'b0;
      end else if (sync2[i] == stable_bit) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        cnt        <= '0;
        stable_bit <= sync2[i];
      end else begin
        cnt <= cnt + CW'(1);
      end
    end

    assign stable[i] = stable_bit;
  end

endmodule

// File: rtl/irrigation_scheduler.sv
// Multi-zone irrigation scheduler: debounced sensors, round-robin zone
// selection, bounded watering runs with a soak pause, and fault handling.
module irrigation_scheduler
  import irrigation_pkg::*;
#(
  parameter int ZONES           = 4,
  parameter int LEVELS          = 3,
  parameter int DEBOUNCE_CYCLES = 1024,
  parameter int MAX_RUN_CYCLES  = 65536,
  parameter int SOAK_CYCLES     = 16384
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [LEVELS-1:0]        water_levels,
  input  logic [ZONES-1:0]         earth_humidity,
  input  logic                     air_humidity,
  input  logic                     low_temperature,
  output logic                     water_supply_valvule,
  output logic                     splinker_bomb,
  output logic                     dripper_valvule,
  output logic [ZONES-1:0]         zone_valvule,
  output logic                     alarm,
  output logic [$clog2(ZONES)-1:0] active_zone,
  output logic [2:0]               state
);

  localparam int ZW = $clog2(ZONES);
  localparam int RW = (MAX_RUN_CYCLES > 1) ? $clog2(MAX_RUN_CYCLES) : 1;
  localparam int SW = (SOAK_CYCLES > 1) ? $clog2(SOAK_CYCLES) : 1;

  logic [LEVELS-1:0]     levels_db;
  logic [ZONES-1:0]      zones_db;
  logic [1:0]            env_db;
  logic [MAX_LEVELS-1:0] levels_ext;
  logic                  conflict;
  logic                  water_ok;
  logic                  mid_ok;
  logic                  full;
  logic [ZONES-1:0]      dry;
  mode_t                 mode_now;

  state_t                state_q;
  state_t                state_d;
  logic [ZW-1:0]         zone_q;
  mode_t                 mode_q;
  logic [ZW-1:0]         rr_ptr;
  logic [RW-1:0]         run_cnt;
  logic [SW-1:0]         soak_cnt;

  logic [ZW:0]           cand;
  logic [ZW-1:0]         sel_zone;
  logic                  sel_found;
  logic                  irrigate_exit;
  logic                  soak_done;

  logic [ZW-1:0]         zone_next;
  mode_t                 mode_next;
  logic [ZONES-1:0]      zone_valve_d;
  logic                  sprinkler_d;
  logic                  dripper_d;
  logic                  supply_d;
  logic                  alarm_d;

  input_debouncer #(.WIDTH(LEVELS), .CYCLES(DEBOUNCE_CYCLES)) u_levels_db (
    .clock (clock),
    .reset (reset),
    .raw   (water_levels),
    .stable(levels_db)
  );

  input_debouncer #(.WIDTH(ZONES), .CYCLES(DEBOUNCE_CYCLES)) u_zones_db (
    .clock (clock),
    .reset (reset),
    .raw   (earth_humidity),
    .stable(zones_db)
  );

  input_debouncer #(.WIDTH(2), .CYCLES(DEBOUNCE_CYCLES)) u_env_db (
    .clock (clock),
    .reset (reset),
    .raw   ({air_humidity, low_temperature}),
    .stable(env_db)
  );

  always_comb begin
    levels_ext = '0;
    levels_ext[LEVELS-1:0] = levels_db;
  end

  assign conflict  = !is_thermometer(levels_ext, LEVELS);
  assign water_ok  = levels_db[0];
  assign mid_ok    = levels_db[1];
  assign full      = levels_db[LEVELS-1];
  assign dry       = ~zones_db;
  assign mode_now  = (!env_db[1] && !env_db[0] && mid_ok) ? SPRINKLER : DRIPPER;

  assign irrigate_exit = zones_db[zone_q] || (run_cnt == RW'(MAX_RUN_CYCLES - 1)) || !water_ok;
  assign soak_done     = (soak_cnt == SW'(SOAK_CYCLES - 1));

  // Round-robin search: first dry zone at or after rr_ptr, wrapping past ZONES-1.
  always_comb begin
    cand      = '0;
    sel_zone  = rr_ptr;
    sel_found = 1'b0;
    for (int i = 0; i < ZONES; i++) begin
      cand = {1'b0, rr_ptr} + (ZW+1)'(i);
      if (cand >= (ZW+1)'(ZONES)) cand = cand - (ZW+1)'(ZONES);
      if (!sel_found && dry[cand[ZW-1:0]]) begin
        sel_found = 1'b1;
        sel_zone  = cand[ZW-1:0];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      zone_q   <= '0;
      mode_q   <= DRIPPER;
      rr_ptr   <= '0;
      run_cnt  <= '0;
      soak_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == SELECT && sel_found) begin
        zone_q <= sel_zone;
        mode_q <= mode_now;
      end
      if (state_q == IRRIGATE && state_d == IRRIGATE) run_cnt <= run_cnt + RW'(1);
      else run_cnt <= '0;
      if (state_q == SOAK && state_d == SOAK) soak_cnt <= soak_cnt + SW'(1);
      else soak_cnt <= '0;
      // The pointer only advances after a completed visit; a fault leaves it alone.
      if (state_q == IRRIGATE && state_d == SOAK) begin
        rr_ptr <= (zone_q == ZW'(ZONES - 1)) ? '0 : zone_q + ZW'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (conflict) begin
      state_d = FAULT;
    end else begin
      case (state_q)
        IDLE:     if (water_ok && |dry) state_d = SELECT;
        SELECT:   state_d = sel_found ? IRRIGATE : IDLE;
        IRRIGATE: if (irrigate_exit) state_d = SOAK;
        SOAK:     if (soak_done) state_d = IDLE;
        FAULT:    state_d = IDLE;
        default:  state_d = IDLE;
      endcase
    end
  end

  // Outputs are computed from the upcoming state so they register together with it.
  always_comb begin
    zone_next    = (state_q == SELECT && sel_found) ? sel_zone : zone_q;
    mode_next    = (state_q == SELECT && sel_found) ? mode_now : mode_q;
    zone_valve_d = '0;
    sprinkler_d  = 1'b0;
    dripper_d    = 1'b0;
    supply_d     = !full && !conflict && (state_d != FAULT);
    alarm_d      = conflict || !mid_ok || (state_d == FAULT);
    if (state_d == IRRIGATE) begin
      zone_valve_d[zone_next] = 1'b1;
      sprinkler_d             = (mode_next == SPRINKLER);
      dripper_d               = (mode_next == DRIPPER);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      water_supply_valvule <= 1'b0;
      splinker_bomb        <= 1'b0;
      dripper_valvule      <= 1'b0;
      zone_valvule         <= '0;
      alarm                <= 1'b0;
      active_zone          <= '0;
      state                <= 3'd0;
    end else begin
      water_supply_valvule <= supply_d;
      splinker_bomb        <= sprinkler_d;
      dripper_valvule      <= dripper_d;
      zone_valvule         <= zone_valve_d;
      alarm                <= alarm_d;
      active_zone          <= zone_next;
      state                <= state_d;
    end
  end

endmodule
